// File: rtl/mem_stage_if.sv
// Execute->memory->writeback bundle: instruction in, memory request/completion, writeback out.
// The stage itself uses the slave view; the driver of instructions and memory model uses master.
interface mem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] aluout;
    logic [15:0] store_data;
    logic        memread;
    logic        memwrite;
    logic [3:0]  dest_reg;
    logic        regwrite;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_dest;
    logic        out_regwrite;
    logic        out_err;

    modport slave (
        input  in_valid, aluout, store_data, memread, memwrite, dest_reg, regwrite,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output out_valid, out_data, out_dest, out_regwrite, out_err
    );

    modport master (
        output in_valid, aluout, store_data, memread, memwrite, dest_reg, regwrite,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  out_valid, out_data, out_dest, out_regwrite, out_err
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU results pass through, loads/stores run one blocking memory access.
// Latency 1 cycle for ALU ops, ack+1 for memory ops; in_ready drops for the whole access.
// Optional access timeout with error writeback under macro MEM_STAGE_TIMEOUT_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        is_load_q, is_load_d;
    logic [3:0]  dest_q, dest_d;
    logic        regwrite_q, regwrite_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic [3:0]  out_dest_q, out_dest_d;
    logic        out_regwrite_q, out_regwrite_d;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        out_err_q, out_err_d;
`endif

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        is_load_d      = is_load_q;
        dest_d         = dest_q;
        regwrite_d     = regwrite_q;
        out_valid_d    = 1'b0;
        out_data_d     = out_data_q;
        out_dest_d     = out_dest_q;
        out_regwrite_d = out_regwrite_q;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d          = cnt_q;
        out_err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.memread || bus.memwrite) begin
                        // Read+write together is a store: memwrite decides the op.
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.memwrite;
                        mem_addr_d  = bus.aluout;
                        mem_wdata_d = bus.memwrite ? bus.store_data : 16'h0000;
                        is_load_d   = ~bus.memwrite;
                        dest_d      = bus.dest_reg;
                        regwrite_d  = bus.regwrite;
`ifdef MEM_STAGE_TIMEOUT_EN
                        cnt_d       = 8'd0;
`endif
                    end else begin
                        out_valid_d    = 1'b1;
                        out_data_d     = bus.aluout;
                        out_dest_d     = bus.dest_reg;
                        out_regwrite_d = bus.regwrite;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_wdata_d    = 16'h0000;
                    out_valid_d    = 1'b1;
                    out_data_d     = is_load_q ? bus.mem_rdata : mem_addr_q;
                    out_dest_d     = dest_q;
                    out_regwrite_d = is_load_q & regwrite_q;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (cnt_q == 8'hFF) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_wdata_d    = 16'h0000;
                    out_valid_d    = 1'b1;
                    out_err_d      = 1'b1;
                    out_data_d     = mem_addr_q;
                    out_dest_d     = dest_q;
                    out_regwrite_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 16'h0000;
            mem_wdata_q    <= 16'h0000;
            is_load_q      <= 1'b0;
            dest_q         <= 4'h0;
            regwrite_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 16'h0000;
            out_dest_q     <= 4'h0;
            out_regwrite_q <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q          <= 8'd0;
            out_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            is_load_q      <= is_load_d;
            dest_q         <= dest_d;
            regwrite_q     <= regwrite_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_dest_q     <= out_dest_d;
            out_regwrite_q <= out_regwrite_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q          <= cnt_d;
            out_err_q      <= out_err_d;
`endif
        end
    end

    assign bus.in_ready     = (state_q == IDLE) && !rst;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_dest     = out_dest_q;
    assign bus.out_regwrite = out_regwrite_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    assign bus.out_err      = out_err_q;
`else
    assign bus.out_err      = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level expectation model.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] last_data;
    logic [3:0]  last_dest;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.in_valid   = 1'b0;
        bus.aluout     = 16'h0;
        bus.store_data = 16'h0;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.dest_reg   = 4'h0;
        bus.regwrite   = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 16'h0;
    endtask

    task automatic present(input logic [15:0] a, input logic [15:0] sd, input logic rd,
                           input logic wr, input logic [3:0] d, input logic rw);
        bus.in_valid   = 1'b1;
        bus.aluout     = a;
        bus.store_data = sd;
        bus.memread    = rd;
        bus.memwrite   = wr;
        bus.dest_reg   = d;
        bus.regwrite   = rw;
    endtask

    // Writeback check: a pulse carries new fields, otherwise data/dest must hold.
    task automatic chk_out(input string tag, input logic v, input logic [15:0] data,
                           input logic [3:0] dest, input logic rw);
        chk1({tag, "_valid"}, bus.out_valid, v);
        if (v) begin
            chk16({tag, "_data"}, bus.out_data, data);
            chk16({tag, "_dest"}, 16'(bus.out_dest), 16'(dest));
            chk1({tag, "_regwrite"}, bus.out_regwrite, rw);
            chk1({tag, "_err"}, bus.out_err, 1'b0);
            last_data = data;
            last_dest = dest;
        end else begin
            chk16({tag, "_hold_data"}, bus.out_data, last_data);
            chk16({tag, "_hold_dest"}, 16'(bus.out_dest), 16'(last_dest));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        @(negedge clk);
        @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk16("rst_mem_addr", bus.mem_addr, 16'h0);
        chk16("rst_mem_wdata", bus.mem_wdata, 16'h0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk16("rst_out_data", bus.out_data, 16'h0);
        chk16("rst_out_dest", 16'(bus.out_dest), 16'h0);
        chk1("rst_out_regwrite", bus.out_regwrite, 1'b0);
        chk1("rst_out_err", bus.out_err, 1'b0);
        last_data = 16'h0;
        last_dest = 4'h0;
        rst = 1'b0;
        #1;
        chk1("rst_release_ready", bus.in_ready, 1'b1);
    endtask

    task automatic alu_result(input logic [15:0] a, input logic [3:0] d, input logic rw);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_out("alu", 1'b1, a, d, rw);
        chk1("alu_in_ready", bus.in_ready, 1'b1);
    endtask

    task automatic do_alu(input logic [15:0] a, input logic [3:0] d, input logic rw);
        chk1("alu_accept_ready", bus.in_ready, 1'b1);
        present(a, 16'($urandom), 1'b0, 1'b0, d, rw);
        alu_result(a, d, rw);
    endtask

    // Memory op acked in ACCESS cycle dly (0 = first). Expected writeback from the op rules.
    task automatic do_mem(input logic [15:0] a, input logic [15:0] sd, input logic rd,
                          input logic wr, input logic [3:0] d, input logic rw, input int dly,
                          input logic [15:0] rdata, input bit keep_alu,
                          input logic [15:0] alu_a, input logic [3:0] alu_d, input logic alu_rw);
        chk1("mem_accept_ready", bus.in_ready, 1'b1);
        present(a, sd, rd, wr, d, rw);
        for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            if (keep_alu) present(alu_a, 16'($urandom), 1'b0, 1'b0, alu_d, alu_rw);
            else          bus.in_valid = 1'b0;
            chk1("acc_mem_req", bus.mem_req, 1'b1);
            chk1("acc_in_ready", bus.in_ready, 1'b0);
            chk16("acc_mem_addr", bus.mem_addr, a);
            chk1("acc_mem_we", bus.mem_we, wr);
            chk16("acc_mem_wdata", bus.mem_wdata, wr ? sd : 16'h0);
            chk_out("acc", 1'b0, 16'h0, 4'h0, 1'b0);
            bus.mem_ack   = (i == dly);
            bus.mem_rdata = (i == dly) ? rdata : 16'($urandom);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk1("done_mem_req", bus.mem_req, 1'b0);
        chk1("done_in_ready", bus.in_ready, 1'b1);
        chk_out(wr ? "store" : "load", 1'b1, wr ? a : rdata, d, wr ? 1'b0 : rw);
    endtask

    task automatic idle_cycle();
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'($urandom);
        bus.mem_rdata = 16'($urandom);
        @(negedge clk);
        chk1("idle_mem_req", bus.mem_req, 1'b0);
        chk1("idle_in_ready", bus.in_ready, 1'b1);
        chk_out("idle", 1'b0, 16'h0, 4'h0, 1'b0);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        last_data = 16'h0;
        last_dest = 4'h0;
        do_reset();

        // Directed: ALU, load with 3 request cycles, store acked immediately.
        do_alu(16'h1234, 4'd3, 1'b1);
        idle_cycle();
        do_mem(16'h0040, 16'h0, 1'b1, 1'b0, 4'd5, 1'b1, 2, 16'hBEEF, 1'b0, 16'h0, 4'h0, 1'b0);
        do_mem(16'h0080, 16'hA5A5, 1'b0, 1'b1, 4'd7, 1'b1, 0, 16'h0, 1'b0, 16'h0, 4'h0, 1'b0);
        idle_cycle();
        // Both read and write set behaves as a store.
        do_mem(16'h0100, 16'h5A5A, 1'b1, 1'b1, 4'd9, 1'b1, 1, 16'hDEAD, 1'b0, 16'h0, 4'h0, 1'b0);
        idle_cycle();

        // Back-to-back: ALU, load, then an ALU op held during the access.
        do_alu(16'h1111, 4'd1, 1'b1);
        do_mem(16'h0200, 16'h0, 1'b1, 1'b0, 4'd2, 1'b1, 1, 16'hCAFE, 1'b1, 16'h2222, 4'd4, 1'b1);
        alu_result(16'h2222, 4'd4, 1'b1);
        idle_cycle();

        // Reset in the second ACCESS cycle of a load, then a late ack.
        present(16'h0040, 16'h0, 1'b1, 1'b0, 4'd5, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk1("rl_mem_req", bus.mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1("rl_mem_req_drop", bus.mem_req, 1'b0);
        chk1("rl_ready_in_rst", bus.in_ready, 1'b0);
        chk1("rl_no_valid", bus.out_valid, 1'b0);
        last_data = 16'h0;
        last_dest = 4'h0;
        rst = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7777;
        #1;
        chk1("rl_ready_after", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk1("rl_late_ack_req", bus.mem_req, 1'b0);
        chk_out("rl_late_ack", 1'b0, 16'h0, 4'h0, 1'b0);
        chk1("rl_late_ack_ready", bus.in_ready, 1'b1);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Load that is never acked: 256 request cycles then an error writeback.
        present(16'h0300, 16'h0, 1'b1, 1'b0, 4'd6, 1'b1);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk1("to_mem_req", bus.mem_req, 1'b1);
            chk1("to_no_valid", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        chk1("to_mem_req_drop", bus.mem_req, 1'b0);
        chk1("to_out_valid", bus.out_valid, 1'b1);
        chk1("to_out_err", bus.out_err, 1'b1);
        chk1("to_out_regwrite", bus.out_regwrite, 1'b0);
        chk1("to_in_ready", bus.in_ready, 1'b1);
        do_reset();
`endif

        // Randomized mix of ALU ops, loads, stores, combined ops and idle ack noise.
        for (int n = 0; n < 60; n++) begin
            int          kind;
            int          dly;
            logic [15:0] a;
            logic [15:0] sd;
            logic [15:0] rd_val;
            logic [3:0]  d;
            logic        rw;
            kind   = int'($urandom_range(0, 4));
            dly    = int'($urandom_range(0, 5));
            a      = 16'($urandom);
            sd     = 16'($urandom);
            rd_val = 16'($urandom);
            d      = 4'($urandom);
            rw     = 1'($urandom);
            case (kind)
                0: do_alu(a, d, rw);
                1: do_mem(a, sd, 1'b1, 1'b0, d, rw, dly, rd_val, 1'b0, 16'h0, 4'h0, 1'b0);
                2: do_mem(a, sd, 1'b0, 1'b1, d, rw, dly, rd_val, 1'b0, 16'h0, 4'h0, 1'b0);
                3: do_mem(a, sd, 1'b1, 1'b1, d, rw, dly, rd_val, 1'b0, 16'h0, 4'h0, 1'b0);
                default: idle_cycle();
            endcase
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  execute stage presents an instruction this cycle.
REQ-004 in_ready  output  1  stage can accept an instruction; high only in IDLE and not in reset.
REQ-005 aluout  input  16  ALU result; memory word address for load/store.
REQ-006 store_data  input  16  write data for stores (SrcReg2 value).
REQ-007 memread / memwrite  input  1 each  load / store indication.
REQ-008 dest_reg  input  4  destination register number; regwrite  input  1  writeback enable.
REQ-009 mem_req  output  1  memory request, registered.
REQ-010 mem_we  output  1  request is a write.
REQ-011 mem_addr  output  16  request address; mem_wdata  output  16  write data.
REQ-012 mem_ack  input  1  memory completion, single-cycle pulse; mem_rdata  input  16  read data, valid with mem_ack.
REQ-013 out_valid  output  1  one-cycle pulse: writeback fields valid.
REQ-014 out_data  output  16  writeback value; out_dest  output  4  register number; out_regwrite  output  1  writeback enable.
REQ-015 out_err  output  1  access aborted by timeout (see Configuration).

Function
REQ-016 States: IDLE, ACCESS; encoding is implementation choice.
REQ-017 IDLE, in_valid, memread=memwrite=0: next cycle out_valid=1, out_data=aluout, out_dest=dest_reg, out_regwrite=regwrite; state stays IDLE (latency 1, throughput 1/cycle).
REQ-018 IDLE, in_valid, memread|memwrite: capture address, store_data, dest_reg, regwrite, op; go to ACCESS; out_valid=0 next cycle.
REQ-019 memread and memwrite both high: treated as store; out_regwrite forced 0.
REQ-020 ACCESS: mem_req=1, in_ready=0; mem_we, mem_addr, mem_wdata held stable until the cycle mem_ack is sampled.
REQ-021 mem_ack sampled in ACCESS at cycle t: state IDLE at t+1, mem_req=0 at t+1, out_valid=1 at t+1.
REQ-022 Load completion: out_data = mem_rdata captured at t, out_regwrite = captured regwrite.
REQ-023 Store completion: out_regwrite=0, out_data=captured address.
REQ-024 mem_ack in IDLE is ignored; no state or output change.
REQ-025 Minimum memory-op occupancy 2 cycles (mem_ack in first ACCESS cycle); new instruction accepted in the cycle after completion.
REQ-026 out_valid is 0 in every cycle not named in REQ-017/021; out_data/out_dest hold last values when out_valid=0.
REQ-027 mem_wdata driven 0 when mem_we=0.

Reset
REQ-028 rst high at a clock edge: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, out_valid, out_data, out_dest, out_regwrite, out_err all 0.
REQ-029 in_ready=0 while rst is high; 1 in the first cycle after rst deasserts.
REQ-030 Reset during ACCESS abandons the transaction: mem_req=0 the next cycle, no out_valid pulse, a late mem_ack ignored per REQ-024.

Configuration
REQ-031 Macro MEM_STAGE_TIMEOUT_EN defined: 8-bit counter cleared on ACCESS entry, incremented each ACCESS cycle without mem_ack; reaching 255 with no mem_ack -> next cycle state IDLE, mem_req=0, out_valid=1, out_err=1, out_regwrite=0; mem_ack on the same cycle as count 255 wins (normal completion).
REQ-032 Macro undefined: no counter; ACCESS waits indefinitely; out_err tied 0.

Verification
REQ-033 ALU op: in_valid, aluout=16'h1234, dest_reg=3, regwrite=1 -> next cycle out_valid=1, out_data=16'h1234, out_dest=3, out_regwrite=1.
REQ-034 Load: aluout=16'h0040, memread=1, dest_reg=5; mem_ack with mem_rdata=16'hBEEF after 3 req cycles -> mem_req high 3 cycles, mem_addr=16'h0040, mem_we=0, then out_valid=1, out_data=16'hBEEF, out_dest=5.
REQ-035 Store: aluout=16'h0080, store_data=16'hA5A5, memwrite=1, mem_ack in first ACCESS cycle -> mem_we=1, mem_wdata=16'hA5A5, out_valid=1 with out_regwrite=0; in_ready=0 exactly one cycle.
REQ-036 Reset in second ACCESS cycle of a load, then mem_ack=1 one cycle later -> mem_req=0, no out_valid, in_ready=1 after rst drops.
REQ-037 Back-to-back: ALU op, load (ack after 1 cycle), ALU op presented while in_ready=0 -> second ALU op accepted only after load completion; out_valid pulses in order ALU, load, ALU.
REQ-038 With MEM_STAGE_TIMEOUT_EN: load with mem_ack never asserted -> mem_req drops after 256 ACCESS cycles, out_valid=1, out_err=1, out_regwrite=0.
